// File: rtl/fetch_pkg.sv
// Shared fetch-side types and helpers.
package fetch_pkg;

   localparam int unsigned INST_W = 32;
   localparam int unsigned PC_W   = 64;

   // One queue entry: instruction word plus the PC it was fetched from.
   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_slot_t;

   // Instruction slot of a PC within its cache line (byte bits [1:0] dropped).
   function automatic int unsigned line_offset(input logic [PC_W-1:0] pc,
                                               input int unsigned line_insts);
      logic [PC_W-1:0] word_idx;
      word_idx = pc >> 2;
      return word_idx[31:0] & (line_insts - 1);
   endfunction

endpackage

// File: rtl/fetch_inst_queue_if.sv
// I-cache line input, Fetch0 read window and control for the instruction queue.
interface fetch_inst_queue_if #(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned LINE_INSTS = 16,
   parameter int unsigned READ_WIDTH = 2
);
   import fetch_pkg::*;

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned DW = $clog2(READ_WIDTH + 1);

   logic                         icache_valid_i;
   logic [PC_W-1:0]              icache_pc_i;
   logic [LINE_INSTS*INST_W-1:0] icache_data_i;
   logic                         instq_full_o;
   logic [READ_WIDTH-1:0]        iq_vld_o;
   logic [READ_WIDTH*PC_W-1:0]   iq_pc_o;
   logic [READ_WIDTH*INST_W-1:0] iq_inst_o;
   logic [DW-1:0]                deq_cnt_i;
   logic                         stall_iq_i;
   logic                         flush_iq_i;
   logic [CW-1:0]                count_o;

   // I-cache and consumer side.
   modport master (
      output icache_valid_i, icache_pc_i, icache_data_i, deq_cnt_i, stall_iq_i, flush_iq_i,
      input  instq_full_o, iq_vld_o, iq_pc_o, iq_inst_o, count_o
   );

   // Queue side.
   modport slave (
      input  icache_valid_i, icache_pc_i, icache_data_i, deq_cnt_i, stall_iq_i, flush_iq_i,
      output instq_full_o, iq_vld_o, iq_pc_o, iq_inst_o, count_o
   );

endinterface

// File: rtl/fetch_queue_ram.sv
// Circular entry storage: contiguous masked multi-port write, windowed read.
module fetch_queue_ram
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned LINE_INSTS = 16,
   parameter int unsigned READ_WIDTH = 2
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] wr_base_i,
   input  logic [LINE_INSTS-1:0]    wr_en_i,
   input  fetch_slot_t              wr_data_i [LINE_INSTS],
   input  logic [$clog2(DEPTH)-1:0] rd_base_i,
   output fetch_slot_t              rd_data_o [READ_WIDTH]
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_slot_t mem_q [DEPTH];

   // Write port k lands at wr_base + k (mod DEPTH); storage is never reset.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < LINE_INSTS; k++) begin
         if (wr_en_i[k]) begin
            mem_q[wr_base_i + AW'(k)] <= wr_data_i[k];
         end
      end
   end

   // Read port k returns the entry at rd_base + k (mod DEPTH).
   always_comb begin
      for (int unsigned k = 0; k < READ_WIDTH; k++) begin
         rd_data_o[k] = mem_q[rd_base_i + AW'(k)];
      end
   end

endmodule

// File: rtl/fetch_inst_queue.sv
// Instruction queue between the I-cache and Fetch0: one line in, up to READ_WIDTH out.
module fetch_inst_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned LINE_INSTS = 16,
   parameter int unsigned READ_WIDTH = 2
) (
   input logic             clk,
   input logic             rst_n,
   fetch_inst_queue_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned OW = $clog2(LINE_INSTS);
   localparam int unsigned DW = $clog2(READ_WIDTH + 1);

   logic [AW-1:0]       rptr_q, rptr_d;
   logic [AW-1:0]       wptr_q, wptr_d;
   logic [CW-1:0]       count_q, count_d;

   logic                full;
   logic                enq;
   logic [OW-1:0]       off;
   logic [CW-1:0]       n_enq;
   logic [DW-1:0]       req;
   logic [CW-1:0]       n_deq;

   logic [INST_W-1:0]   line_inst [LINE_INSTS];
   fetch_slot_t         wr_data   [LINE_INSTS];
   logic [LINE_INSTS-1:0] wr_en;
   fetch_slot_t         rd_data   [READ_WIDTH];

   logic [READ_WIDTH-1:0]        iq_vld;
   logic [READ_WIDTH*PC_W-1:0]   iq_pc;
   logic [READ_WIDTH*INST_W-1:0] iq_inst;

   // Full only looks at registered occupancy so it never depends on this cycle's dequeue.
   assign full = (CW'(DEPTH) - count_q) < CW'(LINE_INSTS);

   // Split the flat cache line into per-slot instruction words.
   always_comb begin
      for (int unsigned k = 0; k < LINE_INSTS; k++) begin
         line_inst[k] = bus.icache_data_i[k*INST_W +: INST_W];
      end
   end

   // Enqueue: pack slots off..LINE_INSTS-1 onto write ports 0..n_enq-1.
   always_comb begin
      logic [OW-1:0] slot;
      slot  = '0;
      enq   = bus.icache_valid_i & ~full & ~bus.flush_iq_i;
      off   = OW'(line_offset(bus.icache_pc_i, LINE_INSTS));
      n_enq = enq ? (CW'(LINE_INSTS) - CW'(off)) : '0;
      for (int unsigned j = 0; j < LINE_INSTS; j++) begin
         slot            = off + OW'(j);
         wr_data[j].pc   = {bus.icache_pc_i[PC_W-1:OW+2], slot, 2'b00};
         wr_data[j].inst = line_inst[slot];
         wr_en[j]        = enq && ((32'(off) + j) < LINE_INSTS);
      end
   end

   // Dequeue: stall blocks it, and the request is clamped to what is actually held.
   always_comb begin
      req   = bus.stall_iq_i ? '0 : bus.deq_cnt_i;
      n_deq = (CW'(req) > count_q) ? count_q : CW'(req);
   end

   // Next pointers and occupancy; flush wins over enqueue and dequeue.
   always_comb begin
      rptr_d  = rptr_q + AW'(n_deq);
      wptr_d  = wptr_q + AW'(n_enq);
      count_d = count_q + n_enq - n_deq;
      if (bus.flush_iq_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end
   end

   // Pointer/count state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   fetch_queue_ram #(
      .DEPTH      (DEPTH),
      .LINE_INSTS (LINE_INSTS),
      .READ_WIDTH (READ_WIDTH)
   ) u_ram (
      .clk       (clk),
      .wr_base_i (wptr_q),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_data),
      .rd_base_i (rptr_q),
      .rd_data_o (rd_data)
   );

   // Read window straight from state; slot valids form a thermometer from occupancy.
   always_comb begin
      iq_vld  = '0;
      iq_pc   = '0;
      iq_inst = '0;
      for (int unsigned k = 0; k < READ_WIDTH; k++) begin
         iq_vld[k]                  = count_q > CW'(k);
         iq_pc[k*PC_W +: PC_W]      = rd_data[k].pc;
         iq_inst[k*INST_W +: INST_W] = rd_data[k].inst;
      end
   end

   assign bus.instq_full_o = full;
   assign bus.iq_vld_o     = iq_vld;
   assign bus.iq_pc_o      = iq_pc;
   assign bus.iq_inst_o    = iq_inst;
   assign bus.count_o      = count_q;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed bench for fetch_inst_queue at the default 32/16/2 configuration.
module tb_fetch_inst_queue;
   import fetch_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_passed = 0;

   fetch_inst_queue_if #(
      .DEPTH      (32),
      .LINE_INSTS (16),
      .READ_WIDTH (2)
   ) bus ();

   fetch_inst_queue #(
      .DEPTH      (32),
      .LINE_INSTS (16),
      .READ_WIDTH (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_passed++;
      else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic idle();
      bus.icache_valid_i = 1'b0;
      bus.deq_cnt_i      = '0;
      bus.stall_iq_i     = 1'b0;
      bus.flush_iq_i     = 1'b0;
   endtask

   // Slot k of the line carries instruction base + k.
   task automatic offer_line(input logic [63:0] pc, input logic [31:0] base);
      bus.icache_valid_i = 1'b1;
      bus.icache_pc_i    = pc;
      for (int k = 0; k < 16; k++) begin
         bus.icache_data_i[k*32 +: 32] = base + 32'(k);
      end
   endtask

   task automatic check_slot0(input string tag, input logic [63:0] pc, input logic [31:0] inst);
      check({tag, ".pc0"}, bus.iq_pc_o[63:0], pc);
      check({tag, ".inst0"}, 64'(bus.iq_inst_o[31:0]), 64'(inst));
   endtask

   task automatic check_slot1(input string tag, input logic [63:0] pc, input logic [31:0] inst);
      check({tag, ".pc1"}, bus.iq_pc_o[127:64], pc);
      check({tag, ".inst1"}, 64'(bus.iq_inst_o[63:32]), 64'(inst));
   endtask

   initial begin
      idle();
      bus.icache_pc_i   = '0;
      bus.icache_data_i = '0;

      // Reset
      tick();
      tick();
      rst_n = 1'b1;
      check("rst.count", 64'(bus.count_o), 64'd0);
      check("rst.vld", 64'(bus.iq_vld_o), 64'd0);
      check("rst.full", 64'(bus.instq_full_o), 64'd0);

      // Aligned line
      offer_line(64'h8000_0000, 32'h100);
      tick();
      idle();
      check("aln.count", 64'(bus.count_o), 64'd16);
      check("aln.vld", 64'(bus.iq_vld_o), 64'd3);
      check("aln.full", 64'(bus.instq_full_o), 64'd0);
      check_slot0("aln", 64'h8000_0000, 32'h100);
      check_slot1("aln", 64'h8000_0004, 32'h101);
      bus.deq_cnt_i = 2'd2;
      for (int i = 0; i < 8; i++) begin
         check("aln.drain_inst0", 64'(bus.iq_inst_o[31:0]), 64'h100 + 64'(2 * i));
         tick();
      end
      idle();
      check("aln.empty_count", 64'(bus.count_o), 64'd0);
      check("aln.empty_vld", 64'(bus.iq_vld_o), 64'd0);

      // Unaligned line: offset 10, six entries
      offer_line(64'h8000_0028, 32'h100);
      tick();
      idle();
      check("unal.count", 64'(bus.count_o), 64'd6);
      check_slot0("unal", 64'h8000_0028, 32'h10A);
      check_slot1("unal", 64'h8000_002C, 32'h10B);
      bus.deq_cnt_i = 2'd1;
      repeat (5) tick();
      check_slot0("unal.sixth", 64'h8000_003C, 32'h10F);
      check("unal.count5", 64'(bus.count_o), 64'd1);
      tick();
      idle();
      check("unal.empty", 64'(bus.count_o), 64'd0);

      // Full and drop; pointers start at 22 so both lines wrap
      offer_line(64'h0000_1000, 32'h200);
      tick();
      offer_line(64'h0000_1040, 32'h300);
      tick();
      check("full.count", 64'(bus.count_o), 64'd32);
      check("full.flag", 64'(bus.instq_full_o), 64'd1);
      offer_line(64'h0000_1080, 32'h400);
      tick();
      idle();
      check("full.drop_count", 64'(bus.count_o), 64'd32);
      check_slot0("full", 64'h0000_1000, 32'h200);
      bus.deq_cnt_i = 2'd2;
      repeat (7) tick();
      check("full.count18", 64'(bus.count_o), 64'd18);
      check("full.flag18", 64'(bus.instq_full_o), 64'd1);
      tick();
      check("full.count16", 64'(bus.count_o), 64'd16);
      check("full.flag16", 64'(bus.instq_full_o), 64'd0);
      check_slot0("full.l2", 64'h0000_1040, 32'h300);
      check_slot1("full.l2", 64'h0000_1044, 32'h301);

      // Simultaneous enqueue and dequeue; this line wraps wptr
      offer_line(64'h0000_2000, 32'h500);
      bus.deq_cnt_i = 2'd2;
      tick();
      idle();
      check("simul.count", 64'(bus.count_o), 64'd30);
      bus.deq_cnt_i = 2'd2;
      repeat (7) tick();
      check("wrap.count16", 64'(bus.count_o), 64'd16);
      check_slot0("wrap.l4", 64'h0000_2000, 32'h500);
      repeat (5) tick();
      idle();
      check("wrap.count6", 64'(bus.count_o), 64'd6);
      check_slot0("wrap.cross", 64'h0000_2028, 32'h50A);
      check_slot1("wrap.cross", 64'h0000_202C, 32'h50B);

      // Stall and clamp
      bus.deq_cnt_i  = 2'd2;
      bus.stall_iq_i = 1'b1;
      tick();
      bus.stall_iq_i = 1'b0;
      check("stall.count", 64'(bus.count_o), 64'd6);
      check_slot0("stall", 64'h0000_2028, 32'h50A);
      repeat (2) tick();
      check("clamp.count2", 64'(bus.count_o), 64'd2);
      bus.deq_cnt_i = 2'd1;
      tick();
      check("clamp.count1", 64'(bus.count_o), 64'd1);
      check("clamp.vld1", 64'(bus.iq_vld_o), 64'd1);
      bus.deq_cnt_i = 2'd2;
      tick();
      idle();
      check("clamp.count0", 64'(bus.count_o), 64'd0);
      check("clamp.vld0", 64'(bus.iq_vld_o), 64'd0);

      // Flush with enqueue and dequeue at count 10
      offer_line(64'h0000_3018, 32'h600);
      tick();
      idle();
      check("flush.pre_count", 64'(bus.count_o), 64'd10);
      check_slot0("flush.pre", 64'h0000_3018, 32'h606);
      offer_line(64'h0000_3040, 32'h700);
      bus.deq_cnt_i  = 2'd2;
      bus.flush_iq_i = 1'b1;
      #1;
      check("flush.same_cycle_count", 64'(bus.count_o), 64'd10);
      tick();
      idle();
      check("flush.count", 64'(bus.count_o), 64'd0);
      check("flush.vld", 64'(bus.iq_vld_o), 64'd0);
      check("flush.full", 64'(bus.instq_full_o), 64'd0);

      // Reset pulse between edges is ignored; a sampled one empties the queue
      offer_line(64'h0000_3018, 32'h600);
      tick();
      idle();
      check("rst.refill", 64'(bus.count_o), 64'd10);
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      check("rst.glitch", 64'(bus.count_o), 64'd10);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst.mid_count", 64'(bus.count_o), 64'd0);
      check("rst.mid_vld", 64'(bus.iq_vld_o), 64'd0);

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
